// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational at fetch; updates from execute land on the next edge.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pcF,
    output logic            predTakenF,
    output logic [XLEN-1:0] predTargetF,
    input  logic            updateE,
    input  logic [XLEN-1:0] pcE,
    input  logic            takenE,
    input  logic [XLEN-1:0] targetE,
    input  logic            predTakenE,
    input  logic [XLEN-1:0] predTargetE,
    output logic            mispredictE,
    output logic [CNTW-1:0] missCount
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    logic            r_valid  [ENTRIES];
    logic [TAGW-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0] r_target [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];
    logic [CNTW-1:0] r_miss_count;

    logic [IDX-1:0]  w_idx_f;
    logic [IDX-1:0]  w_idx_e;
    logic [TAGW-1:0] w_tag_f;
    logic [TAGW-1:0] w_tag_e;
    logic            w_hit_f;
    logic            w_hit_e;

    assign w_idx_f = pcF[IDX+1:2];
    assign w_idx_e = pcE[IDX+1:2];
    assign w_tag_f = pcF[XLEN-1:IDX+2];
    assign w_tag_e = pcE[XLEN-1:IDX+2];

    assign w_hit_f = r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f);
    assign w_hit_e = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);

    // Reads see pre-update contents when fetch and execute share an index.
    assign predTakenF  = w_hit_f & r_ctr[w_idx_f][1];
    assign predTargetF = w_hit_f ? r_target[w_idx_f] : pcF + XLEN'(4);

    assign mispredictE = updateE &
                         ((takenE != predTakenE) | (takenE & (targetE != predTargetE)));
    assign missCount   = r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'd1;
            end
            r_miss_count <= '0;
        end else begin
            if (updateE) begin
                if (w_hit_e) begin
                    if (takenE) begin
                        if (r_ctr[w_idx_e] != 2'd3) r_ctr[w_idx_e] <= r_ctr[w_idx_e] + 2'd1;
                    end else begin
                        if (r_ctr[w_idx_e] != 2'd0) r_ctr[w_idx_e] <= r_ctr[w_idx_e] - 2'd1;
                    end
                end else if (takenE) begin
                    r_valid[w_idx_e] <= 1'b1;
                    r_ctr[w_idx_e]   <= 2'd2;
                end
            end
            if (mispredictE && (r_miss_count != '1)) r_miss_count <= r_miss_count + CNTW'(1);
        end
    end

    // Tag/target carry no reset; a taken resolve always writes them (tag is unchanged on a hit).
    always_ff @(posedge clk) begin
        if (!rst && updateE && takenE) begin
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= targetE;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; second instance uses a 2-bit miss counter.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        predTakenF;
    logic [31:0] predTargetF;
    logic        updateE;
    logic [31:0] pcE;
    logic        takenE;
    logic [31:0] targetE;
    logic        predTakenE;
    logic [31:0] predTargetE;
    logic        mispredictE;
    logic [31:0] missCount;

    logic        predTakenF2;
    logic [31:0] predTargetF2;
    logic        mispredictE2;
    logic [1:0]  missCount2;

    int compared = 0;
    int mismatched = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNTW(32)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF), .predTargetF(predTargetF),
        .updateE(updateE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
        .predTakenE(predTakenE), .predTargetE(predTargetE),
        .mispredictE(mispredictE), .missCount(missCount)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNTW(2)) dut2 (
        .clk(clk), .rst(rst), .pcF(pcF), .predTakenF(predTakenF2), .predTargetF(predTargetF2),
        .updateE(updateE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
        .predTakenE(predTakenE), .predTargetE(predTargetE),
        .mispredictE(mispredictE2), .missCount(missCount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                             input logic ptk, input logic [31:0] ptgt);
        updateE     = 1'b1;
        pcE         = pc;
        takenE      = tk;
        targetE     = tgt;
        predTakenE  = ptk;
        predTargetE = ptgt;
    endtask

    task automatic test_reset;
        rst = 1'b1; updateE = 1'b0; pcF = 32'h100; pcE = '0; takenE = 1'b0;
        targetE = '0; predTakenE = 1'b0; predTargetE = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; pcF = 32'h100;
        #1;
        compared++; if (predTakenF !== 1'b0) begin mismatched++;
            $display("FAIL reset_predTaken: got %0b want 0", predTakenF); end
        compared++; if (predTargetF !== 32'h104) begin mismatched++;
            $display("FAIL reset_predTarget: got %h want 00000104", predTargetF); end
        compared++; if (missCount !== 32'd0) begin mismatched++;
            $display("FAIL reset_missCount: got %0d want 0", missCount); end
        pcF = 32'hFFFF_FFFC;
        #1;
        compared++; if (predTargetF !== 32'h0) begin mismatched++;
            $display("FAIL reset_wrap_target: got %h want 00000000", predTargetF); end
    endtask

    task automatic test_allocate;
        @(negedge clk);
        pcF = 32'h100;
        drive_upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
        #1;
        compared++; if (mispredictE !== 1'b1) begin mismatched++;
            $display("FAIL alloc_mispredict: got %0b want 1", mispredictE); end
        compared++; if (predTakenF !== 1'b0) begin mismatched++;
            $display("FAIL alloc_no_bypass: got %0b want 0", predTakenF); end
        @(negedge clk);
        updateE = 1'b0;
        #1;
        compared++; if (predTakenF !== 1'b1) begin mismatched++;
            $display("FAIL alloc_predTaken: got %0b want 1", predTakenF); end
        compared++; if (predTargetF !== 32'h40) begin mismatched++;
            $display("FAIL alloc_predTarget: got %h want 00000040", predTargetF); end
        compared++; if (missCount !== 32'd1) begin mismatched++;
            $display("FAIL alloc_missCount: got %0d want 1", missCount); end
        compared++; if (mispredictE !== 1'b0) begin mismatched++;
            $display("FAIL alloc_idle_mispredict: got %0b want 0", mispredictE); end
    endtask

    task automatic test_counter;
        // counter walk from 2: taken, predTakenE, expected mispredict, expected predTakenF after
        logic tk_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic ptk_v  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic mis_v  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic pf_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pcF = 32'h100;
            drive_upd(32'h100, tk_v[i], 32'h40, ptk_v[i], 32'h40);
            #1;
            compared++; if (mispredictE !== mis_v[i]) begin mismatched++;
                $display("FAIL ctr_mispredict[%0d]: got %0b want %0b", i, mispredictE, mis_v[i]); end
            @(negedge clk);
            updateE = 1'b0;
            #1;
            compared++; if (predTakenF !== pf_v[i]) begin mismatched++;
                $display("FAIL ctr_predTaken[%0d]: got %0b want %0b", i, predTakenF, pf_v[i]); end
        end
        compared++; if (missCount !== 32'd5) begin mismatched++;
            $display("FAIL ctr_missCount: got %0d want 5", missCount); end
        @(negedge clk);
        drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
        #1;
        compared++; if (mispredictE !== 1'b1) begin mismatched++;
            $display("FAIL target_mispredict: got %0b want 1", mispredictE); end
        @(negedge clk);
        updateE = 1'b0; takenE = 1'b1; predTakenE = 1'b0;
        #1;
        compared++; if (mispredictE !== 1'b0) begin mismatched++;
            $display("FAIL no_update_mispredict: got %0b want 0", mispredictE); end
        compared++; if (predTargetF !== 32'h80) begin mismatched++;
            $display("FAIL target_overwrite: got %h want 00000080", predTargetF); end
        compared++; if (missCount !== 32'd6) begin mismatched++;
            $display("FAIL target_missCount: got %0d want 6", missCount); end
    endtask

    task automatic test_alias;
        @(negedge clk);
        drive_upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
        @(negedge clk);
        updateE = 1'b0; pcF = 32'h100;
        #1;
        compared++; if (predTakenF !== 1'b0 || predTargetF !== 32'h104) begin mismatched++;
            $display("FAIL alias_old_miss: got %0b/%h want 0/00000104", predTakenF, predTargetF); end
        pcF = 32'h140;
        #1;
        compared++; if (predTakenF !== 1'b1 || predTargetF !== 32'h200) begin mismatched++;
            $display("FAIL alias_new_hit: got %0b/%h want 1/00000200", predTakenF, predTargetF); end
        @(negedge clk);
        drive_upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184);
        @(negedge clk);
        updateE = 1'b0; pcF = 32'h140;
        #1;
        compared++; if (predTakenF !== 1'b1 || predTargetF !== 32'h200) begin mismatched++;
            $display("FAIL nt_miss_unchanged: got %0b/%h want 1/00000200", predTakenF, predTargetF); end
        compared++; if (missCount !== 32'd7) begin mismatched++;
            $display("FAIL alias_missCount: got %0d want 7", missCount); end
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        pcF = 32'h140;
        drive_upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h200);
        #1;
        compared++; if (predTakenF !== 1'b1) begin mismatched++;
            $display("FAIL same_cycle_old: got %0b want 1", predTakenF); end
        @(negedge clk);
        updateE = 1'b0;
        #1;
        compared++; if (predTakenF !== 1'b0) begin mismatched++;
            $display("FAIL same_cycle_new: got %0b want 0", predTakenF); end
        compared++; if (missCount !== 32'd8) begin mismatched++;
            $display("FAIL same_cycle_missCount: got %0d want 8", missCount); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rst = 1'b1;
        drive_upd(32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
        @(posedge clk); #1;
        compared++; if (missCount !== 32'd0) begin mismatched++;
            $display("FAIL rst_missCount_during: got %0d want 0", missCount); end
        compared++; if (mispredictE !== 1'b1) begin mismatched++;
            $display("FAIL rst_comb_mispredict: got %0b want 1", mispredictE); end
        @(negedge clk);
        rst = 1'b0; updateE = 1'b0; pcF = 32'h300;
        #1;
        compared++; if (predTakenF !== 1'b0 || predTargetF !== 32'h304) begin mismatched++;
            $display("FAIL rst_no_alloc: got %0b/%h want 0/00000304", predTakenF, predTargetF); end
        pcF = 32'h140;
        #1;
        compared++; if (predTakenF !== 1'b0 || predTargetF !== 32'h144) begin mismatched++;
            $display("FAIL rst_cleared: got %0b/%h want 0/00000144", predTakenF, predTargetF); end
        pcF = 32'h100;
        #1;
        compared++; if (predTargetF !== 32'h104) begin mismatched++;
            $display("FAIL rst_cleared_100: got %h want 00000104", predTargetF); end
        compared++; if (missCount !== 32'd0) begin mismatched++;
            $display("FAIL rst_missCount_after: got %0d want 0", missCount); end
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
            if (i == 3) begin
                #1;
                compared++; if (missCount2 !== 2'd3) begin mismatched++;
                    $display("FAIL sat_before_last: got %0d want 3", missCount2); end
            end
        end
        @(negedge clk);
        updateE = 1'b0;
        #1;
        compared++; if (missCount2 !== 2'd3) begin mismatched++;
            $display("FAIL sat_missCount2: got %0d want 3", missCount2); end
        compared++; if (missCount !== 32'd4) begin mismatched++;
            $display("FAIL sat_missCount32: got %0d want 4", missCount); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_same_cycle();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
